// File: rtl/arduino_comm_pkg.sv
// Shared types and constants for the Arduino coordinate link.
package arduino_comm_pkg;

  typedef enum logic [2:0] {
    WAIT_X,
    SETTLE_X,
    WAIT_Y,
    SETTLE_Y,
    COMMIT
  } seq_state_e;

  localparam int unsigned GPIO_W    = 36;
  localparam int unsigned PHASE_BIT = 10;
  localparam int unsigned DATA_MSB  = 9;
  localparam int unsigned DATA_LSB  = 0;
  localparam int unsigned DATA_W    = DATA_MSB - DATA_LSB + 1;
  localparam int unsigned COORD_W   = 11;
  localparam int unsigned ERR_W     = 8;

  localparam int unsigned DEF_X_MAX = 639;
  localparam int unsigned DEF_Y_MAX = 479;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_pair_t;

  // Zero-extend a raw data word and limit it to the screen edge.
  function automatic logic [COORD_W-1:0] clamp_coord(input logic [DATA_W-1:0] v,
                                                     input logic [COORD_W-1:0] lim);
    logic [COORD_W-1:0] w;
    w = COORD_W'(v);
    return (w > lim) ? lim : w;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer bringing asynchronous GPIO pins into clk.
module gpio_sync #(
  parameter int unsigned WIDTH  = 11,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/arduino_coord_sequencer.sv
// Synchronizes the GPIO coordinate link and sequences X-then-Y transfers
// into an atomically published, clamped coordinate pair.
module arduino_coord_sequencer
  import arduino_comm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned PAIR_TIMEOUT  = 50000,
  parameter int unsigned LINK_TIMEOUT  = 5000000,
  parameter int unsigned X_MAX         = DEF_X_MAX,
  parameter int unsigned Y_MAX         = DEF_Y_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [GPIO_W-1:0]  GPIO,
  output logic [COORD_W-1:0] xCoordinate,
  output logic [COORD_W-1:0] yCoordinate,
  output logic               coord_valid,
  output logic               pair_error,
  output logic               link_alive,
  output logic [ERR_W-1:0]   error_count
);

  localparam int unsigned CNT_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned PT_W    = $clog2(PAIR_TIMEOUT + 1);
  localparam int unsigned LT_W    = $clog2(LINK_TIMEOUT + 1);
  localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 2);

  logic [PHASE_BIT:0] gpio_s;
  logic               gpio_unused;
  logic               ph_s;
  logic [DATA_W-1:0]  d_s;

  gpio_sync #(
    .WIDTH (PHASE_BIT + 1),
    .STAGES(SYNC_STAGES)
  ) u_gpio_sync (
    .clk  (clk),
    .reset(reset),
    .d    (GPIO[PHASE_BIT:0]),
    .q    (gpio_s)
  );

  assign gpio_unused = ^GPIO[GPIO_W-1:PHASE_BIT+1];
  assign ph_s        = gpio_s[PHASE_BIT];
  assign d_s         = gpio_s[DATA_MSB:DATA_LSB];

  seq_state_e         state_q, state_n;
  logic [DATA_W-1:0]  ref_q, ref_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [PT_W-1:0]    pair_tmr_q, pair_tmr_n;
  logic [COORD_W-1:0] x_tmp_q, x_tmp_n;
  logic [COORD_W-1:0] y_tmp_q, y_tmp_n;
  coord_pair_t        coords_q, coords_n;
  logic [LT_W-1:0]    link_cnt_q, link_cnt_n;
  logic               seen_q, seen_n;
  logic               ph_q;
  logic [PRIME_W-1:0] prime_q;
  logic               valid_n, err_n, alive_n;
  logic [ERR_W-1:0]   err_cnt_n;

  // Edges are masked until the synchronizer and phase history hold real pin
  // samples, so reset release never looks like a phase transition.
  logic primed_c, edge_c, rise_c, fall_c, match_c, done_c;
  assign primed_c = (prime_q == PRIME_W'(SYNC_STAGES + 1));
  assign edge_c   = primed_c && (ph_s != ph_q);
  assign rise_c   = edge_c && ph_s;
  assign fall_c   = edge_c && !ph_s;
  assign match_c  = (d_s == ref_q);
  assign done_c   = match_c && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

  assign xCoordinate = coords_q.x;
  assign yCoordinate = coords_q.y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_X;
      ref_q       <= '0;
      cnt_q       <= '0;
      pair_tmr_q  <= '0;
      x_tmp_q     <= '0;
      y_tmp_q     <= '0;
      coords_q    <= '0;
      link_cnt_q  <= '0;
      seen_q      <= 1'b0;
      ph_q        <= 1'b1;
      prime_q     <= '0;
      coord_valid <= 1'b0;
      pair_error  <= 1'b0;
      link_alive  <= 1'b0;
      error_count <= '0;
    end else begin
      state_q     <= state_n;
      ref_q       <= ref_n;
      cnt_q       <= cnt_n;
      pair_tmr_q  <= pair_tmr_n;
      x_tmp_q     <= x_tmp_n;
      y_tmp_q     <= y_tmp_n;
      coords_q    <= coords_n;
      link_cnt_q  <= link_cnt_n;
      seen_q      <= seen_n;
      ph_q        <= ph_s;
      if (!primed_c) prime_q <= prime_q + PRIME_W'(1);
      coord_valid <= valid_n;
      pair_error  <= err_n;
      link_alive  <= alive_n;
      error_count <= err_cnt_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    ref_n      = ref_q;
    cnt_n      = cnt_q;
    pair_tmr_n = pair_tmr_q;
    x_tmp_n    = x_tmp_q;
    y_tmp_n    = y_tmp_q;
    coords_n   = coords_q;
    link_cnt_n = link_cnt_q;
    seen_n     = seen_q;
    valid_n    = 1'b0;
    err_n      = 1'b0;
    alive_n    = 1'b0;
    err_cnt_n  = error_count;

    case (state_q)
      WAIT_X: begin
        if (fall_c) begin
          state_n = SETTLE_X;
          ref_n   = d_s;
          cnt_n   = '0;
        end
      end
      SETTLE_X: begin
        if (edge_c) begin
          err_n   = 1'b1;
          state_n = WAIT_X;
        end else if (done_c) begin
          x_tmp_n    = clamp_coord(ref_q, COORD_W'(X_MAX));
          pair_tmr_n = '0;
          state_n    = WAIT_Y;
        end else if (match_c) begin
          cnt_n = cnt_q + CNT_W'(1);
        end else begin
          ref_n = d_s;
          cnt_n = '0;
        end
      end
      WAIT_Y: begin
        if (rise_c) begin
          state_n = SETTLE_Y;
          ref_n   = d_s;
          cnt_n   = '0;
        end else if (fall_c) begin
          err_n   = 1'b1;
          state_n = SETTLE_X;
          ref_n   = d_s;
          cnt_n   = '0;
        end else if (pair_tmr_q == PT_W'(PAIR_TIMEOUT - 1)) begin
          err_n   = 1'b1;
          x_tmp_n = '0;
          state_n = WAIT_X;
        end else begin
          pair_tmr_n = pair_tmr_q + PT_W'(1);
        end
      end
      SETTLE_Y: begin
        if (edge_c) begin
          err_n   = 1'b1;
          state_n = SETTLE_X;
          ref_n   = d_s;
          cnt_n   = '0;
        end else if (done_c) begin
          y_tmp_n = clamp_coord(ref_q, COORD_W'(Y_MAX));
          state_n = COMMIT;
        end else if (match_c) begin
          cnt_n = cnt_q + CNT_W'(1);
        end else begin
          ref_n = d_s;
          cnt_n = '0;
        end
      end
      COMMIT: begin
        coords_n.x = x_tmp_q;
        coords_n.y = y_tmp_q;
        valid_n    = 1'b1;
        state_n    = WAIT_X;
      end
      default: state_n = WAIT_X;
    endcase

    if (err_n && (error_count != '1)) err_cnt_n = error_count + ERR_W'(1);

    // Link watchdog: restarts on every commit, parks at the timeout value.
    if (valid_n) begin
      link_cnt_n = '0;
      seen_n     = 1'b1;
    end else if (link_cnt_q < LT_W'(LINK_TIMEOUT)) begin
      link_cnt_n = link_cnt_q + LT_W'(1);
    end
    alive_n = seen_n && (link_cnt_n < LT_W'(LINK_TIMEOUT));
  end

endmodule

// File: tb/tb_arduino_coord_sequencer.sv
// Scoreboard bench for arduino_coord_sequencer: directed transfers push expected
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_arduino_coord_sequencer;

  localparam int unsigned PT  = 200;
  localparam int unsigned LT  = 1000;
  localparam int          LAT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [35:0] GPIO;
  logic [10:0] xCoordinate, yCoordinate;
  logic        coord_valid, pair_error, link_alive;
  logic [7:0]  error_count;

  arduino_coord_sequencer #(
    .SYNC_STAGES  (2),
    .SETTLE_CYCLES(4),
    .PAIR_TIMEOUT (PT),
    .LINK_TIMEOUT (LT),
    .X_MAX        (639),
    .Y_MAX        (479)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .GPIO       (GPIO),
    .xCoordinate(xCoordinate),
    .yCoordinate(yCoordinate),
    .coord_valid(coord_valid),
    .pair_error (pair_error),
    .link_alive (link_alive),
    .error_count(error_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    bit          is_err;
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  ecnt;
    int          t;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cur_x = 0, cur_y = 0, exp_errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ph, input int d);
    GPIO       = '0;
    GPIO[10]   = ph;
    GPIO[9:0]  = 10'(d);
  endtask

  task automatic push_pair(input int x, input int y, input int t);
    exp_t e;
    e.is_err = 1'b0;
    e.x = 11'(x);
    e.y = 11'(y);
    e.ecnt = 8'(exp_errs);
    e.t = t;
    q.push_back(e);
    cur_x = x;
    cur_y = y;
  endtask

  task automatic push_err(input int t);
    exp_t e;
    exp_errs++;
    e.is_err = 1'b1;
    e.x = 11'(cur_x);
    e.y = 11'(cur_y);
    e.ecnt = 8'(exp_errs);
    e.t = t;
    q.push_back(e);
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (reset && (coord_valid || pair_error)) begin
      if (q.size() == 0) begin
        chk("spurious_output", 32'({coord_valid, pair_error}), 32'd0);
      end else begin
        e = q.pop_front();
        chk("event_is_error", 32'(pair_error), 32'(e.is_err));
        chk("event_is_valid", 32'(coord_valid), 32'(!e.is_err));
        chk("x_coordinate", 32'(xCoordinate), 32'(e.x));
        chk("y_coordinate", 32'(yCoordinate), 32'(e.y));
        chk("event_cycle", 32'(cyc), 32'(e.t));
        if (e.is_err) chk("error_count_at_error", 32'(error_count), 32'(e.ecnt));
      end
    end
  end

  initial begin
    int c;
    bit alive_seen;
    int prev;
    drive(1'b1, 0);
    tick(3);
    chk("reset_x", 32'(xCoordinate), 32'd0);
    chk("reset_y", 32'(yCoordinate), 32'd0);
    chk("reset_valid", 32'(coord_valid), 32'd0);
    chk("reset_error", 32'(pair_error), 32'd0);
    chk("reset_link", 32'(link_alive), 32'd0);
    chk("reset_errcnt", 32'(error_count), 32'd0);
    reset = 1'b1;
    tick(10);

    // Basic pair, latency from Y edge
    drive(1'b0, 100); tick(20);
    drive(1'b1, 200); push_pair(100, 200, cyc + LAT); tick(20);
    chk("link_alive_after_commit", 32'(link_alive), 32'd1);

    // Clamping at both limits
    drive(1'b0, 1000); tick(20);
    drive(1'b1, 900); push_pair(639, 479, cyc + LAT); tick(20);

    // Missing Y edge: pair timeout
    drive(1'b0, 5); push_err(cyc + 7 + PT); tick(PT + 30);
    chk("errcnt_after_timeout", 32'(error_count), 32'd1);

    // Rising edge while waiting for X is startup alignment, not an error
    drive(1'b1, 3); tick(10);
    drive(1'b0, 7); tick(20);
    drive(1'b1, 9); push_pair(7, 9, cyc + LAT); tick(20);

    // Data unstable during X settle restarts the count without error
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      if (i % 4 != 3) prev = 300 + i;
      drive(1'b0, prev);
      tick(1);
    end
    drive(1'b0, 50); tick(20);
    drive(1'b1, 60); push_pair(50, 60, cyc + LAT); tick(20);
    chk("errcnt_after_toggle", 32'(error_count), 32'd1);

    // Phase edge in the same cycle X settle would complete: edge wins
    drive(1'b0, 70); c = cyc; tick(4);
    drive(1'b1, 70); push_err(c + 7); tick(20);

    // Short Y pulse: falling edge in SETTLE_Y aborts and restarts X
    drive(1'b0, 11); tick(20);
    drive(1'b1, 11); c = cyc; tick(1);
    drive(1'b0, 12); push_err(c + 4); tick(20);
    drive(1'b1, 13); push_pair(12, 13, cyc + LAT); tick(20);
    chk("link_alive_recent", 32'(link_alive), 32'd1);
    tick(LT + 5);
    chk("link_alive_timed_out", 32'(link_alive), 32'd0);
    chk("errcnt_before_reset", 32'(error_count), 32'd3);

    // Reset asserted in WAIT_Y clears everything at once
    drive(1'b0, 20); tick(15);
    #2 reset = 1'b0;
    #1;
    chk("midreset_x", 32'(xCoordinate), 32'd0);
    chk("midreset_y", 32'(yCoordinate), 32'd0);
    chk("midreset_errcnt", 32'(error_count), 32'd0);
    chk("midreset_link", 32'(link_alive), 32'd0);
    cur_x = 0; cur_y = 0; exp_errs = 0;
    tick(2);
    reset = 1'b1;
    alive_seen = 1'b0;
    for (int i = 0; i < int'(LT) + 10; i++) begin
      tick(1);
      if (link_alive) alive_seen = 1'b1;
    end
    chk("link_stays_low_after_reset", 32'(alive_seen), 32'd0);
    chk("post_reset_errcnt", 32'(error_count), 32'd0);

    for (int i = 0; i < 100 && q.size() != 0; i++) tick(1);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arduino_coord_sequencer.md
# arduino_coord_sequencer

Clock-domain controller for the Arduino coordinate link on the GPIO header. It synchronizes the 10-bit data bus and the phase strobe (GPIO[10]) into `clk` and sequences each X-then-Y transfer through a settle/validate state machine. It publishes an atomically updated, clamped coordinate pair with a one-cycle valid pulse to the game logic. It supersedes direct edge-clocked capture of GPIO; nothing downstream samples GPIO directly.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth for GPIO[10:0]
- `SETTLE_CYCLES`, 4, consecutive identical synchronized data samples required before capture (≥1)
- `PAIR_TIMEOUT`, 50000, max clocks in WAIT_Y after X capture (1 ms at 50 MHz)
- `LINK_TIMEOUT`, 5000000, clocks without a commit before `link_alive` drops (100 ms)
- `X_MAX`, 639, clamp ceiling for X
- `Y_MAX`, 479, clamp ceiling for Y
- `clk` in 1: single system clock; all logic is on its rising edge
- `reset` in 1: asynchronous, active-low reset
- `GPIO` in 36: [9:0] coordinate word, [10] phase (falling = X word valid, rising = Y word valid), [35:11] unused
- `xCoordinate` out 11: last committed X, zero-extended, ≤ X_MAX
- `yCoordinate` out 11: last committed Y, zero-extended, ≤ Y_MAX
- `coord_valid` out 1: one-clock pulse in the first cycle a new pair is visible
- `pair_error` out 1: one-clock pulse on any discarded or aborted transfer
- `link_alive` out 1: high while commits arrive within LINK_TIMEOUT
- `error_count` out 8: saturating count of `pair_error` pulses

## Operation
- Reset values: coordinates 0; `coord_valid`, `pair_error`, `link_alive` 0; `error_count` 0; state WAIT_X; synchronizer flops 0; phase history 1.
- `ph_s` and `d_s` are the synchronized phase and data. An edge flag fires in the cycle `ph_s` differs from its registered copy.
- WAIT_X: falling edge goes to SETTLE_X. A rising edge is ignored with no error, as startup alignment.
- SETTLE_X: on entry, ref = `d_s` and cnt = 0. Each cycle: if `d_s` == ref, cnt++; otherwise ref = `d_s` and cnt = 0.
  - When cnt reaches SETTLE_CYCLES−1 with a match, latch x_tmp = min(ref, X_MAX), clear the pair timer, and go to WAIT_Y.
  - Any phase edge in this state pulses `pair_error` and goes to WAIT_X.
- WAIT_Y: a rising edge goes to SETTLE_Y.
  - A falling edge (X resent) pulses `pair_error` and goes to SETTLE_X.
  - If the timer reaches PAIR_TIMEOUT, pulse `pair_error`, discard x_tmp, and go to WAIT_X.
- SETTLE_Y: same stability rule as SETTLE_X. On success, y_tmp = min(ref, Y_MAX) and go to COMMIT.
  - A falling edge pulses `pair_error` and goes to SETTLE_X.
- COMMIT: one cycle. It registers both coordinates together, so they are never updated singly, and goes to WAIT_X.
- `link_alive`: the link counter clears on commit and saturates at LINK_TIMEOUT. `link_alive` = (at least one commit since reset) && counter < LINK_TIMEOUT.
- `error_count` holds at 255.

## Timing
- All outputs are registered.
- Pin edge sampled at clk cycle 0 with steady data: `coord_valid` is high in cycle SYNC_STAGES+SETTLE_CYCLES+2 (8 at defaults). The coordinates change in the same cycle.
- Data changing during settle restarts cnt, adding latency, with no error.
- Edge and stable-complete in the same cycle: the edge wins.
- Timeout and rising edge in the same cycle in WAIT_Y: the edge wins.
- Minimum sustained rate: one pair per 2·(SETTLE_CYCLES+1)+1 clocks after synchronization.
- Reset asserted mid-transfer immediately forces reset values. Partial x_tmp is lost. No `coord_valid` or `pair_error` is generated on reset release.

## Structure
- Package `arduino_comm_pkg` holds:
  - state enum (WAIT_X, SETTLE_X, WAIT_Y, SETTLE_Y, COMMIT);
  - GPIO field constants (PHASE_BIT=10, DATA_MSB=9, DATA_LSB=0);
  - default screen limits;
  - a packed coord-pair struct.
- Sub-module `gpio_sync` is a parameterized WIDTH×STAGES flop synchronizer with reset value 0, instantiated for GPIO[10:0].
- The FSM, timers and clamps live in the top module.

## Test plan
- X=100 (phase falls), steady 20 clocks, Y=200 (phase rises) → one `coord_valid`; x=100, y=200 at the specified latency; no `pair_error`.
- X=1000, Y=900 → x=639, y=479.
- X=5, then no rising edge for PAIR_TIMEOUT clocks → one `pair_error`; coordinates unchanged; `error_count`=1.
- Rising-edge-first startup, then X=7, Y=9 → no error; x=7, y=9.
- Data toggling 3 of every 4 clocks during SETTLE_X, then steady X=50, Y=60 → no error; commit delayed by the restart count.
- Reset pulled low in WAIT_Y → all outputs 0 immediately. After release, 0 commits for LINK_TIMEOUT+10 clocks → `link_alive` stays 0.
